uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, the counterpart of the existing UART transmitter. It samples the serial line i_uart_rxd, detects the start bit, and recovers p_DATA_BIT data bits LSB-first, sampling each at mid-bit. It checks the stop bit and presents the byte on a one-cycle valid strobe. It sits at the device pin boundary and feeds the command/DMA control path.

Parameters:
p_DIV, 16'd434, clock cycles per bit minus one (bit period = p_DIV+1 cycles; 434 gives 115200 baud at 50 MHz)
p_DATA_BIT, 4'd8, number of data bits per frame, range 5..8

Ports:
i_local_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_uart_rxd  input  1  serial line, asynchronous to i_local_clk, idle high
o_data  output  p_DATA_BIT  received byte, LSB = first bit on the line; held until next frame completes
o_valid  output  1  one-cycle pulse, o_data valid
o_frame_err  output  1  one-cycle pulse, stop bit sampled low
o_busy  output  1  high while any state other than S_IDLE is active

Behaviour:
- Reset is asynchronous and active-low, on i_rst_n. One clock: i_local_clk.
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_busy=0, FSM=S_IDLE, and the synchronizer flops = 1.
- Input sync: i_uart_rxd passes through a 2-flop synchronizer, then one more flop for edge detect. All logic uses the synchronized signal rxd_s.
- Falling edge = rxd_s_d==1 && rxd_s==0.
- Counters: r_div_cnt is 16 bits. It clears on every state change. It wraps to 0 when it reaches p_DIV; otherwise it increments. r_bit_cnt is 4 bits.
- FSM states: S_IDLE, S_START, S_DATA, S_STOP.
- S_IDLE: on a falling edge, go to S_START with r_div_cnt=0.
- S_START: at r_div_cnt == p_DIV>>1 (mid start bit), sample rxd_s.
  - If rxd_s is 1, it was a glitch: return to S_IDLE with no outputs.
  - If rxd_s is 0, go to S_DATA with r_div_cnt=0 and r_bit_cnt=0. Later samples therefore fall at mid-bit.
- S_DATA: at r_div_cnt == p_DIV, shift rxd_s into a shift register from the MSB side (LSB-first line order) and increment r_bit_cnt.
  - When r_bit_cnt == p_DATA_BIT-1 and this sample is taken, go to S_STOP.
- S_STOP: at r_div_cnt == p_DIV, sample the stop bit.
  - If 1: o_data <= shift register, o_valid=1 for one cycle.
  - If 0: o_frame_err=1 for one cycle; o_data is unchanged and o_valid stays 0.
  - Either way, go to S_IDLE in the same cycle.
- Re-arm: the next falling edge is accepted in S_IDLE only. After a frame error, the line must return high before a new start is detected, because the falling-edge requirement enforces this.
- Latency: o_valid asserts about (p_DATA_BIT+1)*(p_DIV+1) + (p_DIV>>1) + 4 cycles after the start-bit falling edge on the pin. The 4 covers 3 sync flops plus the registered output.
- Line held low (break): the frame completes with o_frame_err. The FSM then waits in S_IDLE until a new falling edge.
- Reset mid-frame: everything returns to reset values immediately and no pulse is emitted.
- For p_DATA_BIT < 8, the shift register is p_DATA_BIT wide, so no alignment is needed.
- o_valid and o_frame_err never assert in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - state encodings S_IDLE/S_START/S_DATA/S_STOP (2-bit)
  - default p_DIV and p_DATA_BIT constants, shared with the transmitter
- One natural sub-module: sync_2ff, a generic 2-flop synchronizer with a reset value parameter. It is reusable across the codebase.
- The rest is a single module.

Test Plan:
1. p_DIV=15. Send 0xA5 with a valid stop bit. Required: one o_valid pulse with o_data=8'hA5, o_frame_err=0, o_busy low afterwards.
2. Send 0x00 and then 0xFF back-to-back, with no idle between the stop bit and the next start. Required: two o_valid pulses with o_data=8'h00 then 8'hFF.
3. Drive a 3-cycle low glitch in idle. Required: no o_valid and no o_frame_err. o_busy rises and then returns to 0 within p_DIV/2+4 cycles.
4. Send 0x3C with the stop bit forced low. Required: o_frame_err pulses once, o_valid stays 0, o_data keeps its previous value. Then the line goes high and 0x11 is sent, giving o_valid with 8'h11.
5. Assert i_rst_n low during bit 4 of a frame. Required: outputs go to 0 at once and no pulse follows. After release, a clean 0x5A frame is received correctly.
6. Loopback against the UART transmitter with p_DIV=434, sending bytes 0x00..0xFF. Required: every byte is received in order with zero frame errors.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver FSM state encoding and the
//               default bit divider and frame width. The transmitter uses the
//               same defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM state encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  // Clock cycles per bit minus one (434 -> 115200 baud at 50 MHz)
  localparam logic [15:0] UART_DIV_DEFAULT      = 16'd434;
  // Data bits per frame (5..8)
  localparam logic [3:0]  UART_DATA_BIT_DEFAULT = 4'd8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchronizer for a single-bit asynchronous
//               input. Both flops reset to RESET_VAL.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input
//               q     - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Synchronizes the serial line, detects the
//               start bit, samples p_DATA_BIT data bits LSB-first at mid-bit,
//               checks the stop bit and emits the word on a one-cycle strobe.
// Ports       : i_local_clk - system clock
//               i_rst_n     - asynchronous active-low reset
//               i_uart_rxd  - serial line (asynchronous, idle high)
//               o_data      - last good word, held until the next good frame
//               o_valid     - one-cycle pulse, o_data updated
//               o_frame_err - one-cycle pulse, stop bit sampled low
//               o_busy      - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [15:0] p_DIV      = UART_DIV_DEFAULT,
  parameter logic [3:0]  p_DATA_BIT = UART_DATA_BIT_DEFAULT
) (
  input  logic                  i_local_clk,
  input  logic                  i_rst_n,
  input  logic                  i_uart_rxd,
  output logic [p_DATA_BIT-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam logic [15:0] c_HALF_DIV = p_DIV >> 1;
  localparam logic [3:0]  c_LAST_BIT = p_DATA_BIT - 4'd1;

  logic                  rxd_s;
  logic                  rxd_s_d;
  logic                  fall;
  uart_state_t           state;
  logic [15:0]           r_div_cnt;
  logic [3:0]            r_bit_cnt;
  logic [p_DATA_BIT-1:0] r_shift;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (i_local_clk),
    .rst_n (i_rst_n),
    .d     (i_uart_rxd),
    .q     (rxd_s)
  );

  // Extra stage used only for falling-edge detection
  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) rxd_s_d <= 1'b1;
    else          rxd_s_d <= rxd_s;
  end

  assign fall = rxd_s_d & ~rxd_s;

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;

      // Free-running bit timer; every state change below overrides it to 0
      if (r_div_cnt == p_DIV) r_div_cnt <= '0;
      else                    r_div_cnt <= r_div_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (fall) begin
            state     <= S_START;
            r_div_cnt <= '0;
            o_busy    <= 1'b1;
          end
        end

        S_START: begin
          // Re-check the line at mid start bit to reject glitches; restarting
          // the timer here puts every later sample at mid-bit.
          if (r_div_cnt == c_HALF_DIV) begin
            r_div_cnt <= '0;
            if (rxd_s) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state     <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
        end

        S_DATA: begin
          if (r_div_cnt == p_DIV) begin
            // LSB arrives first, so shift in from the MSB side
            r_shift   <= {rxd_s, r_shift[p_DATA_BIT-1:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == c_LAST_BIT) begin
              state     <= S_STOP;
              r_div_cnt <= '0;
            end
          end
        end

        S_STOP: begin
          if (r_div_cnt == p_DIV) begin
            if (rxd_s) begin
              o_data  <= r_shift;
              o_valid <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
            state     <= S_IDLE;
            r_div_cnt <= '0;
            o_busy    <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          r_div_cnt <= '0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_rx
`default_nettype wire
